// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/decode/execute control sequencer for the single-cycle datapath.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module ctrl_seq #(
  parameter int WD = 32,
  parameter int WAD = 5,
  parameter logic [WD-1:0] RESET_PC = '0,
  parameter int FETCH_TO = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req,
  output logic [WD-1:0]  imem_addr,
  input  logic           imem_valid,
  input  logic [WD-1:0]  imem_rdata,
  output logic [WD-1:0]  instr,
  output logic [WAD-1:0] AdIn,
  output logic [WAD-1:0] AdOut1,
  output logic [WAD-1:0] AdOut2,
  output logic           ALUsrc,
  output logic [2:0]     ALUctrl,
  output logic [1:0]     ResultSrc,
  output logic [1:0]     IMMsrc,
  output logic           RegWrite,
  output logic           RamWrite,
  output logic [WD-1:0]  PCN,
  input  logic           EQ,
  input  logic [WD-1:0]  IMM,
  output logic           halt,
  output logic [1:0]     err,
  output logic [WD-1:0]  instret
);

  localparam int CW = (FETCH_TO < 2) ? 1 : $clog2(FETCH_TO);
  localparam logic [CW-1:0] CTR_LAST = CW'(FETCH_TO - 1);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

  state_t        state;
  logic [WD-1:0] pc;
  logic [CW-1:0] ctr;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal, is_ecall, is_br, br_ne, is_jal, reg_wr, ram_wr;
  logic       taken, misalign, retire;
  logic [WD-1:0] target;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign AdIn      = instr[11:7];
  assign AdOut1    = instr[19:15];
  assign AdOut2    = instr[24:20];
  assign imem_addr = pc;
  assign PCN       = pc + WD'(4);

  always_comb begin
    legal     = 1'b0;
    is_ecall  = 1'b0;
    is_br     = 1'b0;
    br_ne     = 1'b0;
    is_jal    = 1'b0;
    reg_wr    = 1'b0;
    ram_wr    = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = 3'b000;
    ResultSrc = 2'b00;
    IMMsrc    = 2'b00;
    if (instr == WD'(32'h0000_0073)) begin
      is_ecall = 1'b1;
    end else begin
      case (opcode)
        7'b0110011: begin
          if (funct7 == 7'b0000000) begin
            case (funct3)
              3'b000: begin legal = 1'b1; ALUctrl = 3'b000; end
              3'b111: begin legal = 1'b1; ALUctrl = 3'b010; end
              3'b110: begin legal = 1'b1; ALUctrl = 3'b011; end
              3'b010: begin legal = 1'b1; ALUctrl = 3'b101; end
              default: ;
            endcase
          end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            legal   = 1'b1;
            ALUctrl = 3'b001;
          end
          reg_wr = legal;
        end
        7'b0010011: begin
          if (funct3 == 3'b000) begin
            legal  = 1'b1;
            ALUsrc = 1'b1;
            reg_wr = 1'b1;
          end
        end
        7'b0000011: begin
          if (funct3 == 3'b010) begin
            legal     = 1'b1;
            ALUsrc    = 1'b1;
            ResultSrc = 2'b01;
            reg_wr    = 1'b1;
          end
        end
        7'b0100011: begin
          if (funct3 == 3'b010) begin
            legal  = 1'b1;
            ALUsrc = 1'b1;
            IMMsrc = 2'b01;
            ram_wr = 1'b1;
          end
        end
        7'b1100011: begin
          if (funct3 == 3'b000 || funct3 == 3'b001) begin
            legal   = 1'b1;
            is_br   = 1'b1;
            br_ne   = funct3[0];
            ALUctrl = 3'b001;
            IMMsrc  = 2'b10;
          end
        end
        7'b1101111: begin
          legal     = 1'b1;
          is_jal    = 1'b1;
          IMMsrc    = 2'b11;
          ResultSrc = 2'b10;
          reg_wr    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A misaligned target kills the instruction: no strobes and no retirement.
  assign taken    = is_jal | (is_br & (EQ ^ br_ne));
  assign target   = taken ? (pc + IMM) : (pc + WD'(4));
  assign misalign = |target[1:0];
  assign retire   = legal & ~misalign;
  assign RegWrite = (state == S_EXEC) & reg_wr & retire & (AdIn != '0);
  assign RamWrite = (state == S_EXEC) & ram_wr & retire;

  // The request is registered out of FETCH, so it is seen during the first WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      instr    <= WD'(32'h0000_0013);
      halt     <= 1'b0;
      err      <= 2'b00;
      imem_req <= 1'b0;
      ctr      <= '0;
    end else begin
      imem_req <= 1'b0;
      case (state)
        S_FETCH: begin
          imem_req <= 1'b1;
          ctr      <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            instr <= imem_rdata;
            state <= S_EXEC;
          end else if (ctr == CTR_LAST) begin
            halt  <= 1'b1;
            err   <= 2'b11;
            state <= S_HALT;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        S_EXEC: begin
          if (is_ecall) begin
            halt  <= 1'b1;
            err   <= 2'b00;
            state <= S_HALT;
          end else if (!legal) begin
            halt  <= 1'b1;
            err   <= 2'b01;
            state <= S_HALT;
          end else if (misalign) begin
            halt  <= 1'b1;
            err   <= 2'b10;
            state <= S_HALT;
          end else begin
            pc    <= target;
            state <= S_FETCH;
          end
        end
        S_HALT: ;
      endcase
    end
  end

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (state == S_EXEC && !is_ecall && retire) begin
      instret <= instret + 1'b1;
    end
  end
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: mnemonic-level reference model checked every cycle,
// plus directed programs with literal expectations.
module tb_ctrl_seq;
  localparam int WD = 32;
  localparam int WAD = 5;
  localparam int FETCH_TO = 15;

  localparam logic [31:0] ADDI1  = 32'h0050_0093;
  localparam logic [31:0] ADDI2  = 32'h0070_0113;
  localparam logic [31:0] ADD3   = 32'h0020_81B3;
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0C63;
  localparam logic [31:0] BNE20  = 32'h0010_1A63;
  localparam logic [31:0] JAL16  = 32'h0100_00EF;
  localparam logic [31:0] ADD_X0 = 32'h0020_8033;
  localparam logic [31:0] SW_I   = 32'h0020_A023;
  localparam logic [31:0] LW_I   = 32'h0000_A283;
  localparam logic [31:0] BAD_I  = 32'hFFFF_FFFF;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_valid = 1'b0;
  logic [WD-1:0] imem_rdata = '0;
  logic EQ = 1'b0;
  logic [WD-1:0] IMM = '0;
  logic imem_req, RegWrite, RamWrite, ALUsrc, halt;
  logic [WD-1:0] imem_addr, instr, PCN, instret;
  logic [WAD-1:0] AdIn, AdOut1, AdOut2;
  logic [2:0] ALUctrl;
  logic [1:0] ResultSrc, IMMsrc, err;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_seq #(.WD(WD), .WAD(WAD), .RESET_PC('0), .FETCH_TO(FETCH_TO)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr(instr),
    .AdIn(AdIn), .AdOut1(AdOut1), .AdOut2(AdOut2), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .ResultSrc(ResultSrc), .IMMsrc(IMMsrc),
    .RegWrite(RegWrite), .RamWrite(RamWrite), .PCN(PCN), .EQ(EQ), .IMM(IMM),
    .halt(halt), .err(err), .instret(instret)
  );

  typedef enum {MN_ADD, MN_SUB, MN_AND, MN_OR, MN_SLT, MN_ADDI, MN_LW, MN_SW,
                MN_BEQ, MN_BNE, MN_JAL, MN_ECALL, MN_BAD} mn_t;

  typedef struct packed {
    logic       alusrc;
    logic [2:0] aluctrl;
    logic [1:0] ressrc;
    logic [1:0] immsrc;
    logic       wr_reg;
    logic       wr_ram;
  } ctl_t;

  function automatic mn_t classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (w == 32'h0000_0073) return MN_ECALL;
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) return MN_ADD;
    if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return MN_SUB;
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) return MN_AND;
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) return MN_OR;
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd2) return MN_SLT;
    if (op == 7'h13 && f3 == 3'd0) return MN_ADDI;
    if (op == 7'h03 && f3 == 3'd2) return MN_LW;
    if (op == 7'h23 && f3 == 3'd2) return MN_SW;
    if (op == 7'h63 && f3 == 3'd0) return MN_BEQ;
    if (op == 7'h63 && f3 == 3'd1) return MN_BNE;
    if (op == 7'h6F) return MN_JAL;
    return MN_BAD;
  endfunction

  // Fields: alusrc, aluctrl, resultsrc, immsrc, regwrite-class, ramwrite-class.
  function automatic ctl_t expect_ctl(input mn_t m);
    case (m)
      MN_ADD:  return '{1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0};
      MN_SUB:  return '{1'b0, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0};
      MN_AND:  return '{1'b0, 3'b010, 2'b00, 2'b00, 1'b1, 1'b0};
      MN_OR:   return '{1'b0, 3'b011, 2'b00, 2'b00, 1'b1, 1'b0};
      MN_SLT:  return '{1'b0, 3'b101, 2'b00, 2'b00, 1'b1, 1'b0};
      MN_ADDI: return '{1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0};
      MN_LW:   return '{1'b1, 3'b000, 2'b01, 2'b00, 1'b1, 1'b0};
      MN_SW:   return '{1'b1, 3'b000, 2'b00, 2'b01, 1'b0, 1'b1};
      MN_BEQ:  return '{1'b0, 3'b001, 2'b00, 2'b10, 1'b0, 1'b0};
      MN_BNE:  return '{1'b0, 3'b001, 2'b00, 2'b10, 1'b0, 1'b0};
      MN_JAL:  return '{1'b0, 3'b000, 2'b10, 2'b11, 1'b1, 1'b0};
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] next_pc(input mn_t m, input logic [31:0] pc,
                                          input logic eq, input logic [31:0] imm);
    bit jump;
    jump = (m == MN_JAL) || (m == MN_BEQ && eq) || (m == MN_BNE && !eq);
    return jump ? pc + imm : pc + 32'd4;
  endfunction

  function automatic logic [31:0] exp_instret(input logic [31:0] n);
`ifdef RETIRE_CNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  localparam int PH_FETCH = 0, PH_WAIT = 1, PH_EXEC = 2, PH_HALT = 3;
  int m_phase, m_wait;
  logic [31:0] m_pc, m_instr, m_instret;
  logic m_halt, m_req;
  logic [1:0] m_err;

  // Reference model: one transition per clock, reset asynchronously.
  initial forever begin : model
    mn_t mn;
    logic [31:0] tgt;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = PH_FETCH; m_wait = 0; m_pc = 0; m_instr = 32'h13;
      m_instret = 0; m_halt = 0; m_req = 0; m_err = 0;
    end else begin
      m_req = 0;
      if (m_phase == PH_FETCH) begin
        m_req = 1; m_wait = 0; m_phase = PH_WAIT;
      end else if (m_phase == PH_WAIT) begin
        if (imem_valid) begin
          m_instr = imem_rdata; m_phase = PH_EXEC;
        end else begin
          m_wait++;
          if (m_wait == FETCH_TO) begin m_halt = 1; m_err = 2'd3; m_phase = PH_HALT; end
        end
      end else if (m_phase == PH_EXEC) begin
        mn = classify(m_instr);
        tgt = next_pc(mn, m_pc, EQ, IMM);
        if (mn == MN_ECALL) begin m_halt = 1; m_err = 2'd0; m_phase = PH_HALT; end
        else if (mn == MN_BAD) begin m_halt = 1; m_err = 2'd1; m_phase = PH_HALT; end
        else if (tgt[1:0] != 0) begin m_halt = 1; m_err = 2'd2; m_phase = PH_HALT; end
        else begin m_pc = tgt; m_instret++; m_phase = PH_FETCH; end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  initial forever begin : compare
    mn_t mn;
    ctl_t c;
    logic [31:0] tgt;
    bit ok;
    @(negedge clk);
    #1;
    if (rst_n && cmp_en) begin
      mn = classify(m_instr);
      c = expect_ctl(mn);
      tgt = next_pc(mn, m_pc, EQ, IMM);
      ok = (m_phase == PH_EXEC) && (tgt[1:0] == 0) && mn != MN_BAD && mn != MN_ECALL;
      checkOutput("cyc_imem_req", 32'(imem_req), 32'(m_req));
      checkOutput("cyc_imem_addr", imem_addr, m_pc);
      checkOutput("cyc_pcn", PCN, m_pc + 32'd4);
      checkOutput("cyc_instr", instr, m_instr);
      checkOutput("cyc_adin", 32'(AdIn), 32'(m_instr[11:7]));
      checkOutput("cyc_adout1", 32'(AdOut1), 32'(m_instr[19:15]));
      checkOutput("cyc_adout2", 32'(AdOut2), 32'(m_instr[24:20]));
      checkOutput("cyc_alusrc", 32'(ALUsrc), 32'(c.alusrc));
      checkOutput("cyc_aluctrl", 32'(ALUctrl), 32'(c.aluctrl));
      checkOutput("cyc_resultsrc", 32'(ResultSrc), 32'(c.ressrc));
      checkOutput("cyc_immsrc", 32'(IMMsrc), 32'(c.immsrc));
      checkOutput("cyc_regwrite", 32'(RegWrite), 32'(ok && c.wr_reg && m_instr[11:7] != 0));
      checkOutput("cyc_ramwrite", 32'(RamWrite), 32'(ok && c.wr_ram));
      checkOutput("cyc_halt", 32'(halt), 32'(m_halt));
      checkOutput("cyc_err", 32'(err), 32'(m_err));
      checkOutput("cyc_instret", instret, exp_instret(m_instret));
    end
  end

  task automatic doReset();
    rst_n = 1'b0;
    imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    imem_valid = 1'b0;
    #1;
  endtask

  // Answers the next fetch after lat idle cycles; returns in the EXEC cycle.
  task automatic applyStimulus(input logic [31:0] word, input int lat, input logic eq_v, input logic [31:0] imm_v);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) begin seen = 1'b1; break; end
    end
    checkOutput("req_seen", 32'(seen), 32'd1);
    repeat (lat) @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = word;
    EQ = eq_v;
    IMM = imm_v;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = '0;
    #1;
  endtask

  initial begin : main
    int cycles;
    @(negedge clk);
    #1;
    checkOutput("rst_halt", 32'(halt), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_instr", instr, 32'h13);
    checkOutput("rst_addr", imem_addr, 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
    doReset();

    applyStimulus(ADDI1, 1, 1'b0, 32'd5);
    checkOutput("addi_regwrite", 32'(RegWrite), 32'd1);
    checkOutput("addi_adin", 32'(AdIn), 32'd1);
    checkOutput("addi_alusrc", 32'(ALUsrc), 32'd1);
    step();
    checkOutput("addi_next_addr", imem_addr, 32'd4);
    checkOutput("addi_instret", instret, exp_instret(32'd1));

    applyStimulus(ADD3, 0, 1'b0, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = BAD_I;
    checkOutput("add_regwrite", 32'(RegWrite), 32'd1);
    step();
    checkOutput("exec_valid_ignored", instr, ADD3);
    checkOutput("add_next_addr", imem_addr, 32'd8);

    applyStimulus(BEQ_M8, 0, 1'b1, -32'sd8);
    checkOutput("beq_aluctrl", 32'(ALUctrl), 32'd1);
    checkOutput("beq_immsrc", 32'(IMMsrc), 32'd2);
    checkOutput("beq_regwrite", 32'(RegWrite), 32'd0);
    step();
    checkOutput("beq_taken_addr", imem_addr, 32'd0);

    applyStimulus(ADDI2, 0, 1'b0, 32'd7); step();
    applyStimulus(ADDI2, 2, 1'b0, 32'd7); step();
    applyStimulus(BEQ_M8, 0, 1'b0, -32'sd8); step();
    checkOutput("beq_nottaken_addr", imem_addr, 32'd12);

    applyStimulus(BNE20, 0, 1'b0, 32'd20); step();
    checkOutput("bne_taken_addr", imem_addr, 32'h20);

    applyStimulus(JAL16, 0, 1'b0, 32'd16);
    checkOutput("jal_resultsrc", 32'(ResultSrc), 32'd2);
    checkOutput("jal_pcn", PCN, 32'h24);
    checkOutput("jal_regwrite", 32'(RegWrite), 32'd1);
    step();
    checkOutput("jal_next_addr", imem_addr, 32'h30);

    applyStimulus(ADD_X0, 0, 1'b0, 32'd0);
    checkOutput("x0_regwrite", 32'(RegWrite), 32'd0);
    step();
    applyStimulus(SW_I, 0, 1'b0, 32'd0);
    checkOutput("sw_ramwrite", 32'(RamWrite), 32'd1);
    checkOutput("sw_immsrc", 32'(IMMsrc), 32'd1);
    step();
    applyStimulus(LW_I, 0, 1'b0, 32'd0);
    checkOutput("lw_resultsrc", 32'(ResultSrc), 32'd1);
    step();
    checkOutput("lw_next_addr", imem_addr, 32'h3C);

    applyStimulus(BEQ_M8, 0, 1'b1, 32'd2);
    checkOutput("misal_regwrite", 32'(RegWrite), 32'd0);
    step();
    checkOutput("misal_halt", 32'(halt), 32'd1);
    checkOutput("misal_err", 32'(err), 32'd2);
    checkOutput("misal_addr", imem_addr, 32'h3C);
    checkOutput("misal_instret", instret, exp_instret(32'd11));
    repeat (3) step();
    checkOutput("halt_no_req", 32'(imem_req), 32'd0);

    doReset();
    applyStimulus(BAD_I, 0, 1'b0, 32'd0);
    checkOutput("bad_regwrite", 32'(RegWrite), 32'd0);
    checkOutput("bad_ramwrite", 32'(RamWrite), 32'd0);
    step();
    checkOutput("bad_halt", 32'(halt), 32'd1);
    checkOutput("bad_err", 32'(err), 32'd1);
    checkOutput("bad_addr", imem_addr, 32'd0);

    doReset();
    applyStimulus(ECALL, 0, 1'b0, 32'd0);
    step();
    checkOutput("ecall_halt", 32'(halt), 32'd1);
    checkOutput("ecall_err", 32'(err), 32'd0);

    doReset();
    cycles = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (halt) begin cycles = i; break; end
    end
    checkOutput("timeout_halt", 32'(halt), 32'd1);
    checkOutput("timeout_err", 32'(err), 32'd3);
    checkOutput("timeout_cycles", 32'(cycles), 32'(FETCH_TO + 1));

    doReset();
    applyStimulus(ADDI1, 0, 1'b0, 32'd5);
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_addr", imem_addr, 32'd0);
    checkOutput("async_rst_req", 32'(imem_req), 32'd0);
    checkOutput("async_rst_instr", instr, 32'h13);
    checkOutput("async_rst_halt", 32'(halt), 32'd0);
    doReset();
    applyStimulus(ADDI2, 1, 1'b0, 32'd7);
    checkOutput("refetch_instr", instr, ADDI2);
    step();
    checkOutput("refetch_next_addr", imem_addr, 32'd4);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
